debug_data_receiver: RTL and testbench

DEBUG_DATA_RECEIVER -- requirements
Module: debug_data_receiver

---
 rtl/debug_data_receiver_if.sv | 51 +++++
 rtl/debug_data_receiver.sv | 131 +++++++++++++
 tb/tb_debug_data_receiver.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_data_receiver_if.sv
// debug_data_receiver_if
//   Bundles the serial link from the debug data sender, the consumer
//   handshake and the receiver status flags into one interface.
//
//   Signals:
//     sin        serial data, MSB of the frame first
//     sync_in    high for exactly the first bit of a frame
//     data_ack   consumer takes the held frame when high with data_valid
//     data       last completed frame, data[FRAME_BITS-1] = first bit
//     data_valid data holds a frame the consumer has not taken yet
//     busy       frame reception in progress
//     frame_err  one-cycle pulse: sync_in arrived in the middle of a frame
//     overrun    sticky: a completed frame was dropped
//
//   Modports:
//     master  sender/consumer side (drives sin, sync_in, data_ack)
//     slave   receiver side (drives data and status)
interface debug_data_receiver_if #(
  parameter int FRAME_BITS = 40
);
  logic                  sin;
  logic                  sync_in;
  logic                  data_ack;
  logic [FRAME_BITS-1:0] data;
  logic                  data_valid;
  logic                  busy;
  logic                  frame_err;
  logic                  overrun;

  modport master (
    output sin,
    output sync_in,
    output data_ack,
    input  data,
    input  data_valid,
    input  busy,
    input  frame_err,
    input  overrun
  );

  modport slave (
    input  sin,
    input  sync_in,
    input  data_ack,
    output data,
    output data_valid,
    output busy,
    output frame_err,
    output overrun
  );
endinterface

// File: rtl/debug_data_receiver.sv
// debug_data_receiver
//   Deserialises frames from the debug data sender. A frame is FRAME_BITS
//   bits, MSB first, with sync_in marking the first bit. The completed frame
//   is presented on data/data_valid on the same edge that samples its last
//   bit and is held until the consumer acknowledges it.
//
//   Ports:
//     clk    sole clock; the sender drives the link on the falling edge,
//            so the inputs are sampled directly without synchronisers
//     rst_n  synchronous active-low reset
//     rx     debug_data_receiver_if.slave (link, handshake, status)
//
//   Parameters:
//     FRAME_BITS  payload bits per frame
//     CNT_W       bit counter width, 2**CNT_W must exceed FRAME_BITS
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for sync_in; sin ignored (sender trailing gap)
//   SHIFT | collecting frame bits; cnt_q = bits sampled so far
module debug_data_receiver #(
  parameter int FRAME_BITS = 40,
  parameter int CNT_W      = 6
) (
  input logic                  clk,
  input logic                  rst_n,
  debug_data_receiver_if.slave rx
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  ovr_q, ovr_d;
  logic                  loading;
  logic                  complete;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    err_d    = 1'b0;
    loading  = 1'b0;
    complete = 1'b0;
    data_d   = data_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;

    case (state_q)
      IDLE: begin
        if (rx.sync_in) begin
          shift_d = FRAME_BITS'(rx.sin);
          cnt_d   = ONE_CNT;
          state_d = SHIFT;
          loading = 1'b1;
        end
      end
      SHIFT: begin
        loading = 1'b1;
        // A sync on the edge taking the last bit can only come from a
        // broken sender; finishing the frame wins over restarting.
        if (rx.sync_in && (cnt_q != LAST_CNT)) begin
          err_d   = 1'b1;
          shift_d = FRAME_BITS'(rx.sin);
          cnt_d   = ONE_CNT;
        end else begin
          shift_d = (shift_q << 1) | FRAME_BITS'(rx.sin);
          cnt_d   = cnt_q + ONE_CNT;
        end
      end
    endcase

    // Decided on the next counter value so that a frame completes on the
    // very edge that samples its last bit.
    if (loading && (cnt_d == FULL_CNT)) begin
      complete = 1'b1;
      state_d  = IDLE;
    end

    if (complete) begin
      // An ack on the completion edge frees the holding register in time
      // for the new frame, so nothing is lost.
      if (!valid_q || rx.data_ack) begin
        data_d  = shift_d;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx.data_ack) begin
      valid_d = 1'b0;
    end
  end

  assign rx.data       = data_q;
  assign rx.data_valid = valid_q;
  assign rx.busy       = (state_q == SHIFT);
  assign rx.frame_err  = err_q;
  assign rx.overrun    = ovr_q;

endmodule

// File: tb/tb_debug_data_receiver.sv
module tb_debug_data_receiver;
  localparam int FB = 40;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic rst_n;

  debug_data_receiver_if #(.FRAME_BITS(FB)) dif ();

  debug_data_receiver #(.FRAME_BITS(FB), .CNT_W(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rx   (dif.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [FB-1:0] exp_q[$];
  logic [FB-1:0] exp_f;
  logic          prev_valid = 1'b0;
  logic [FB-1:0] prev_data  = '0;

  // Scoreboard: each new frame appearing on data (valid rising, or data
  // replaced while valid) must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && dif.data_valid && (!prev_valid || dif.data !== prev_data)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL deliver: got frame %h, no frame expected", dif.data);
      end else begin
        exp_f = exp_q.pop_front();
        if (dif.data !== exp_f) begin
          bad++;
          $display("FAIL deliver: got %h want %h", dif.data, exp_f);
        end
      end
    end
    prev_valid <= dif.data_valid;
    prev_data  <= dif.data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic s, input logic sy, input logic ack);
    @(negedge clk);
    dif.sin      = s;
    dif.sync_in  = sy;
    dif.data_ack = ack;
  endtask

  task automatic drive_bits(input logic [FB-1:0] f, input int first, input int last);
    for (int i = first; i <= last; i++) step(f[FB-1-i], (i == 0), 1'b0);
  endtask

  task automatic gap(input int n);
    repeat (n) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
  endtask

  task automatic chk_valid(input string nm, input logic want);
    total++;
    if (dif.data_valid !== want) begin
      bad++;
      $display("FAIL %s: data_valid=%b want %b", nm, dif.data_valid, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    total++;
    if (dif.data !== '0 || dif.data_valid !== 1'b0 || dif.busy !== 1'b0 ||
        dif.frame_err !== 1'b0 || dif.overrun !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: data=%h valid=%b busy=%b err=%b ovr=%b want all 0",
               dif.data, dif.data_valid, dif.busy, dif.frame_err, dif.overrun);
    end
    step(1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      total++;
      if (dif.busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_sync_ignored: cycle %0d busy=%b want 0", i, dif.busy);
      end
    end
  endtask

  task automatic test_single();
    logic [FB-1:0] f;
    f = 40'hA5_1234_5678;
    exp_q.push_back(f);
    step(f[FB-1], 1'b1, 1'b0);
    for (int i = 1; i < FB; i++) begin
      step(f[FB-1-i], 1'b0, 1'b0);
      total++;
      if (dif.busy !== 1'b1 || dif.frame_err !== 1'b0) begin
        bad++;
        $display("FAIL single_busy: after %0d bits busy=%b err=%b want 1/0", i, dif.busy, dif.frame_err);
      end
      chk_valid("single_not_yet", 1'b0);
    end
    gap(1);
    chk_valid("single_done", 1'b1);
    total++;
    if (dif.busy !== 1'b0 || dif.data !== f) begin
      bad++;
      $display("FAIL single_data: busy=%b data=%h want 0/%h", dif.busy, dif.data, f);
    end
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk_valid("single_ack", 1'b0);
    total++;
    if (dif.data !== f) begin
      bad++;
      $display("FAIL single_hold: data=%h want %h", dif.data, f);
    end
  endtask

  task automatic test_back_to_back();
    logic [FB-1:0] f[2];
    f[0] = 40'h00_0000_00FF;
    f[1] = 40'hFF_0000_0000;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(f[k]);
      drive_bits(f[k], 0, FB-1);
      step(1'b0, 1'b0, 1'b1);
      chk_valid("b2b_done", 1'b1);
      step(1'b0, 1'b0, 1'b0);
      chk_valid("b2b_ack", 1'b0);
      gap(4);
    end
    total++;
    if (dif.overrun !== 1'b0) begin
      bad++;
      $display("FAIL b2b_overrun: overrun=%b want 0", dif.overrun);
    end
  endtask

  task automatic test_overrun();
    logic [FB-1:0] f1, f2;
    f1 = 40'hC0_FFEE_1234;
    f2 = 40'h01_2345_6789;
    exp_q.push_back(f1);
    drive_bits(f1, 0, FB-1);
    gap(6);
    chk_valid("ovr_first", 1'b1);
    drive_bits(f2, 0, FB-1);
    total++;
    if (dif.overrun !== 1'b0) begin
      bad++;
      $display("FAIL ovr_early: overrun=%b want 0 before completion", dif.overrun);
    end
    gap(1);
    chk_valid("ovr_second", 1'b1);
    total++;
    if (dif.overrun !== 1'b1 || dif.data !== f1) begin
      bad++;
      $display("FAIL ovr_drop: overrun=%b data=%h want 1/%h", dif.overrun, dif.data, f1);
    end
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk_valid("ovr_ack", 1'b0);
    total++;
    if (dif.overrun !== 1'b1) begin
      bad++;
      $display("FAIL ovr_sticky: overrun=%b want 1", dif.overrun);
    end
    gap(5);
    total++;
    if (dif.overrun !== 1'b1) begin
      bad++;
      $display("FAIL ovr_sticky_late: overrun=%b want 1", dif.overrun);
    end
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    total++;
    if (dif.overrun !== 1'b0) begin
      bad++;
      $display("FAIL ovr_reset: overrun=%b want 0", dif.overrun);
    end
    gap(2);
  endtask

  task automatic test_frame_err();
    logic [FB-1:0] junk, f;
    junk = FB'({$urandom(), $urandom()});
    f    = 40'h12_3456_789A;
    drive_bits(junk, 0, 19);
    exp_q.push_back(f);
    step(f[FB-1], 1'b1, 1'b0);
    total++;
    if (dif.frame_err !== 1'b0) begin
      bad++;
      $display("FAIL ferr_before: frame_err=%b want 0", dif.frame_err);
    end
    step(f[FB-2], 1'b0, 1'b0);
    total++;
    if (dif.frame_err !== 1'b1 || dif.busy !== 1'b1) begin
      bad++;
      $display("FAIL ferr_pulse: frame_err=%b busy=%b want 1/1", dif.frame_err, dif.busy);
    end
    chk_valid("ferr_no_valid", 1'b0);
    step(f[FB-3], 1'b0, 1'b0);
    total++;
    if (dif.frame_err !== 1'b0) begin
      bad++;
      $display("FAIL ferr_one_cycle: frame_err=%b want 0", dif.frame_err);
    end
    drive_bits(f, 3, FB-2);
    chk_valid("ferr_not_early", 1'b0);
    drive_bits(f, FB-1, FB-1);
    gap(1);
    chk_valid("ferr_done", 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk_valid("ferr_ack", 1'b0);
    gap(4);
  endtask

  task automatic test_ack_on_completion();
    logic [FB-1:0] f1, f2;
    f1 = 40'h0F_0F0F_0F0F;
    f2 = 40'hF0_F0F0_F0F1;
    exp_q.push_back(f1);
    drive_bits(f1, 0, FB-1);
    gap(6);
    chk_valid("ackc_first", 1'b1);
    exp_q.push_back(f2);
    drive_bits(f2, 0, FB-2);
    step(f2[0], 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk_valid("ackc_still_valid", 1'b1);
    total++;
    if (dif.data !== f2 || dif.overrun !== 1'b0) begin
      bad++;
      $display("FAIL ackc_data: data=%h overrun=%b want %h/0", dif.data, dif.overrun, f2);
    end
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk_valid("ackc_ack", 1'b0);
    gap(4);
  endtask

  task automatic test_mid_reset();
    logic [FB-1:0] fp, fa, fn;
    fp = 40'h5A_5A5A_5A5A;
    fa = FB'({$urandom(), $urandom()});
    fn = 40'hDE_ADBE_EF01;
    exp_q.push_back(fp);
    drive_bits(fp, 0, FB-1);
    gap(6);
    chk_valid("mrst_prior", 1'b1);
    drive_bits(fa, 0, 14);
    step(fa[FB-1-15], 1'b0, 1'b0);
    rst_n = 1'b0;
    for (int j = 16; j <= 18; j++) begin
      step(fa[FB-1-j], 1'b0, 1'b0);
      total++;
      if (dif.data !== '0 || dif.data_valid !== 1'b0 || dif.busy !== 1'b0 ||
          dif.frame_err !== 1'b0 || dif.overrun !== 1'b0) begin
        bad++;
        $display("FAIL mrst_zero: bit %0d data=%h valid=%b busy=%b err=%b ovr=%b want all 0",
                 j, dif.data, dif.data_valid, dif.busy, dif.frame_err, dif.overrun);
      end
    end
    rst_n = 1'b1;
    for (int j = 19; j < FB; j++) begin
      step(fa[FB-1-j], 1'b0, 1'b0);
      total++;
      if (dif.busy !== 1'b0 || dif.data_valid !== 1'b0) begin
        bad++;
        $display("FAIL mrst_ignore: bit %0d busy=%b valid=%b want 0/0", j, dif.busy, dif.data_valid);
      end
    end
    gap(3);
    exp_q.push_back(fn);
    drive_bits(fn, 0, FB-1);
    gap(1);
    chk_valid("mrst_next", 1'b1);
    total++;
    if (dif.data !== fn) begin
      bad++;
      $display("FAIL mrst_data: data=%h want %h", dif.data, fn);
    end
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk_valid("mrst_ack", 1'b0);
  endtask

  initial begin
    dif.sin      = 1'b1;
    dif.sync_in  = 1'b1;
    dif.data_ack = 1'b0;
    rst_n        = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_ack_on_completion();
    test_mid_reset();
    gap(2);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_frames: %0d expected frames never delivered, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
